// File: rtl/sensor_conditioner.sv
// Per-channel input conditioner: two-flop synchronizer, polarity fix and
// consecutive-sample debounce, with edge pulses and a sticky, ack-cleared event flag.
module sensor_conditioner #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pin_i,
  input  logic [NUM_CH-1:0] ack_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] evt_o
);

  localparam int unsigned       CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_CH-1:0] POL_MASK = {NUM_CH{ACTIVE_LOW}};

  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic [NUM_CH-1:0] evt_q, evt_d;
  logic [NUM_CH-1:0] sample;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  // Next-state: any agreeing sample discards progress; acceptance on the last count
  always_comb begin
    sync1_d = pin_i;
    sync2_d = sync1_q;
    sample  = sync2_q ^ POL_MASK;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      cnt_d[ch] = '0;
      if (sample[ch] != level_q[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          level_d[ch] = sample[ch];
          rise_d[ch]  = sample[ch];
          fall_d[ch]  = ~sample[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
        end
      end
    end
    // Set wins over a simultaneous ack
    evt_d = rise_d | (evt_q & ~ack_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= POL_MASK;
      sync2_q <= POL_MASK;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      evt_q   <= '0;
      for (int ch = 0; ch < int'(NUM_CH); ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
      for (int ch = 0; ch < int'(NUM_CH); ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign evt_o   = evt_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: instance A (DEBOUNCE=4, active-high) and
// instance B (DEBOUNCE=1, active-low), checked cycle by cycle against an expectation queue.
module tb_sensor_conditioner;

  logic       clk;
  logic       rst_n;
  logic [1:0] pin_a, ack_a, level_a, rise_a, fall_a, evt_a;
  logic [1:0] pin_b, ack_b, level_b, rise_b, fall_b, evt_b;

  logic [7:0] exp_q[$];
  int         checks;
  int         errors;

  sensor_conditioner #(.NUM_CH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .pin_i(pin_a), .ack_i(ack_a),
    .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a), .evt_o(evt_a)
  );

  sensor_conditioner #(.NUM_CH(2), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pin_i(pin_b), .ack_i(ack_b),
    .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b), .evt_o(evt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mk(input logic [1:0] l, input logic [1:0] r,
                                    input logic [1:0] f, input logic [1:0] e);
    return {l, r, f, e};
  endfunction

  function automatic logic [1:0] b2(input bit c1, input bit c0);
    return {c1, c0};
  endfunction

  task automatic test_reset();
    logic [7:0] got, exp;
    #2;
    checks++;
    if ({level_a, rise_a, fall_a, evt_a} !== 8'h00) begin
      errors++;
      $display("FAIL reset_a got %h exp 00", {level_a, rise_a, fall_a, evt_a});
    end
    checks++;
    if ({level_b, rise_b, fall_b, evt_b} !== 8'h00) begin
      errors++;
      $display("FAIL reset_b got %h exp 00", {level_b, rise_b, fall_b, evt_b});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      exp_q.push_back(8'h00);
      @(posedge clk); #1;
      got = {level_b, rise_b, fall_b, evt_b};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL idle_b e%0d got %h exp %h", e, got, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] got, exp;
    pin_a = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      exp_q.push_back(mk(b2(0, e >= 6), b2(0, e == 6), 2'b00, b2(0, e >= 6)));
      @(posedge clk); #1;
      got = {level_a, rise_a, fall_a, evt_a};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clean_press e%0d got %h exp %h", e, got, exp);
      end
    end
  endtask

  task automatic test_release_ack();
    logic [7:0] got, exp;
    ack_a = 2'b01;
    exp_q.push_back(mk(2'b01, 2'b00, 2'b00, 2'b00));
    @(posedge clk); #1;
    ack_a = 2'b00;
    got = {level_a, rise_a, fall_a, evt_a};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ack_clear got %h exp %h", got, exp);
    end
    pin_a = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      exp_q.push_back(mk(b2(0, e < 6), 2'b00, b2(0, e == 6), 2'b00));
      @(posedge clk); #1;
      got = {level_a, rise_a, fall_a, evt_a};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL release e%0d got %h exp %h", e, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0]  got, exp;
    logic [15:0] pats [2];
    pats[0] = 16'h0007;
    pats[1] = 16'h0077;
    for (int p = 0; p < 2; p++) begin
      for (int e = 0; e < 14; e++) begin
        pin_a = {1'b0, pats[p][e]};
        exp_q.push_back(8'h00);
        @(posedge clk); #1;
        got = {level_a, rise_a, fall_a, evt_a};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL glitch p%0d e%0d got %h exp %h", p, e, got, exp);
        end
      end
    end
  endtask

  task automatic test_ack_collision();
    logic [7:0] got, exp;
    ack_a = 2'b01;
    pin_a = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      exp_q.push_back(mk(b2(0, e >= 6), b2(0, e == 6), 2'b00, b2(0, e == 6)));
      @(posedge clk); #1;
      got = {level_a, rise_a, fall_a, evt_a};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL collision_press e%0d got %h exp %h", e, got, exp);
      end
    end
    pin_a = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      exp_q.push_back(mk(b2(0, e < 6), 2'b00, b2(0, e == 6), 2'b00));
      @(posedge clk); #1;
      got = {level_a, rise_a, fall_a, evt_a};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL collision_release e%0d got %h exp %h", e, got, exp);
      end
    end
    ack_a = 2'b00;
  endtask

  task automatic test_reset_mid_count();
    logic [7:0] got, exp;
    pin_a = 2'b10;
    for (int e = 1; e <= 8; e++) begin
      exp_q.push_back(mk(b2(e >= 6, 0), b2(e == 6, 0), 2'b00, b2(e >= 6, 0)));
      @(posedge clk); #1;
      got = {level_a, rise_a, fall_a, evt_a};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ch1_press e%0d got %h exp %h", e, got, exp);
      end
    end
    pin_a = 2'b11;
    for (int e = 1; e <= 3; e++) begin
      exp_q.push_back(mk(2'b10, 2'b00, 2'b00, 2'b10));
      @(posedge clk); #1;
      got = {level_a, rise_a, fall_a, evt_a};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_count e%0d got %h exp %h", e, got, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({level_a, rise_a, fall_a, evt_a} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got %h exp 00", {level_a, rise_a, fall_a, evt_a});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      exp_q.push_back(mk(e >= 6 ? 2'b11 : 2'b00, e == 6 ? 2'b11 : 2'b00, 2'b00,
                         e >= 6 ? 2'b11 : 2'b00));
      @(posedge clk); #1;
      got = {level_a, rise_a, fall_a, evt_a};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL post_reset e%0d got %h exp %h", e, got, exp);
      end
    end
    pin_a = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      exp_q.push_back(mk(e < 6 ? 2'b11 : 2'b00, 2'b00, e == 6 ? 2'b11 : 2'b00, 2'b11));
      @(posedge clk); #1;
      got = {level_a, rise_a, fall_a, evt_a};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fall_keeps_evt e%0d got %h exp %h", e, got, exp);
      end
    end
    ack_a = 2'b11;
    exp_q.push_back(8'h00);
    @(posedge clk); #1;
    ack_a = 2'b00;
    got = {level_a, rise_a, fall_a, evt_a};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ack_both got %h exp %h", got, exp);
    end
  endtask

  task automatic test_active_low_fast();
    logic [7:0] got, exp;
    for (int e = 1; e <= 3; e++) begin
      exp_q.push_back(8'h00);
      @(posedge clk); #1;
      got = {level_b, rise_b, fall_b, evt_b};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL al_idle e%0d got %h exp %h", e, got, exp);
      end
    end
    pin_b = 2'b10;
    for (int e = 1; e <= 5; e++) begin
      exp_q.push_back(mk(b2(0, e >= 3), b2(0, e == 3), 2'b00, b2(0, e >= 3)));
      @(posedge clk); #1;
      got = {level_b, rise_b, fall_b, evt_b};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL al_press e%0d got %h exp %h", e, got, exp);
      end
    end
    pin_b = 2'b11;
    for (int e = 1; e <= 5; e++) begin
      exp_q.push_back(mk(b2(0, e < 3), 2'b00, b2(0, e == 3), 2'b01));
      @(posedge clk); #1;
      got = {level_b, rise_b, fall_b, evt_b};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL al_release e%0d got %h exp %h", e, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    pin_a  = 2'b00;
    ack_a  = 2'b00;
    pin_b  = 2'b11;
    ack_b  = 2'b00;
    test_reset();
    test_clean_press();
    test_release_ack();
    test_glitch();
    test_ack_collision();
    test_reset_mid_count();
    test_active_low_fast();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
